// File: rtl/gerente_pilha_if.sv
// Handshake and stack-RAM bus of the stack controller.
// slave  : the controller side (gerente_pilha).
// master : the environment side (requester plus the stack RAM).
interface gerente_pilha_if #(
    parameter int WIDTH = 16,
    parameter int AW    = 5
) ();
    logic             req_valid;
    logic             req_ready;
    logic [1:0]       req_op;
    logic [WIDTH-1:0] req_data;
    logic             resp_valid;
    logic             resp_ready;
    logic [WIDTH-1:0] resp_data;
    logic             resp_err;
    logic [AW-1:0]    mem_addr;
    logic             mem_wren;
    logic [WIDTH-1:0] mem_wdata;
    logic [WIDTH-1:0] mem_rdata;

    modport slave (
        input  req_valid, req_op, req_data, resp_ready, mem_rdata,
        output req_ready, resp_valid, resp_data, resp_err,
               mem_addr, mem_wren, mem_wdata
    );

    modport master (
        output req_valid, req_op, req_data, resp_ready, mem_rdata,
        input  req_ready, resp_valid, resp_data, resp_err,
               mem_addr, mem_wren, mem_wdata
    );
endinterface

// File: rtl/gerente_pilha.sv
// Stack controller: serves push / pop / replace-top / peek requests one at a
// time against an external synchronous-read stack RAM, tracking occupancy.
module gerente_pilha #(
    parameter  int WIDTH = 16,
    parameter  int DEPTH = 32,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic            clock,
    input  logic            reset,
    gerente_pilha_if.slave  bus,
    output logic [AW:0]     count,
    output logic            full,
    output logic            empty
);

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ,
        WAIT,
        RESP
    } state_t;

    localparam logic [1:0]    OP_PUSH = 2'b00;
    localparam logic [1:0]    OP_POP  = 2'b01;
    localparam logic [1:0]    OP_REPL = 2'b10;
    localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW:0]   ONE_C   = (AW+1)'(1);
    localparam logic [AW-1:0] ONE_A   = AW'(1);

    state_t        state;
    logic [1:0]    op_q;
    logic [AW-1:0] top_addr;
    logic          reject;

    // Address of the current top entry; when the stack is full the low AW
    // bits of count wrap to 0 so this still lands on DEPTH-1.
    assign top_addr = count[AW-1:0] - ONE_A;

    // A push needs a free slot, every other operation needs an occupied one.
    assign reject = (bus.req_op == OP_PUSH) ? full : empty;

    assign full           = (count == DEPTH_C);
    assign empty          = (count == '0);
    assign bus.req_ready  = (state == IDLE);
    assign bus.resp_valid = (state == RESP);

    // Single FSM: accepts one operation, sequences the RAM access, then holds
    // the response until the requester takes it.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            op_q          <= OP_PUSH;
            count         <= '0;
            bus.resp_data <= '0;
            bus.resp_err  <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wren  <= 1'b0;
            bus.mem_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        op_q <= bus.req_op;
                        if (reject) begin
                            bus.resp_err  <= 1'b1;
                            bus.resp_data <= '0;
                            state         <= RESP;
                        end else if (bus.req_op == OP_PUSH) begin
                            bus.mem_addr  <= count[AW-1:0];
                            bus.mem_wren  <= 1'b1;
                            bus.mem_wdata <= bus.req_data;
                            state         <= WRITE;
                        end else if (bus.req_op == OP_REPL) begin
                            bus.mem_addr  <= top_addr;
                            bus.mem_wren  <= 1'b1;
                            bus.mem_wdata <= bus.req_data;
                            state         <= WRITE;
                        end else begin
                            bus.mem_addr  <= top_addr;
                            state         <= READ;
                        end
                    end
                end
                WRITE: begin
                    bus.mem_wren  <= 1'b0;
                    bus.resp_data <= bus.mem_wdata;
                    bus.resp_err  <= 1'b0;
                    if (op_q == OP_PUSH) begin
                        count <= count + ONE_C;
                    end
                    state <= RESP;
                end
                READ: begin
                    state <= WAIT;
                end
                WAIT: begin
                    bus.resp_data <= bus.mem_rdata;
                    bus.resp_err  <= 1'b0;
                    if (op_q == OP_POP) begin
                        count <= count - ONE_C;
                    end
                    state <= RESP;
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gerente_pilha.sv
// Testbench for gerente_pilha: directed operations with a scoreboard of
// expected responses checked by an independent response monitor.
module tb_gerente_pilha;

    localparam int WIDTH = 16;
    localparam int DEPTH = 32;
    localparam int AW    = 5;

    localparam logic [1:0] OP_PUSH = 2'b00;
    localparam logic [1:0] OP_POP  = 2'b01;
    localparam logic [1:0] OP_REPL = 2'b10;
    localparam logic [1:0] OP_PEEK = 2'b11;

    typedef struct {
        logic [WIDTH-1:0] data;
        logic             err;
        int               lat;
        int               acc;
    } exp_t;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic [AW:0]   count;
    logic          full;
    logic          empty;

    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    int            wren_cycles = 0;
    exp_t          sb[$];

    logic [WIDTH-1:0] ram [0:DEPTH-1];

    gerente_pilha_if #(.WIDTH(WIDTH), .AW(AW)) bus ();

    gerente_pilha #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    // 100 MHz clock
    always #5 clock = ~clock;

    // Cycle counter used for latency measurement
    always @(posedge clock) cyc++;

    // Synchronous-read stack RAM model
    always @(posedge clock) begin
        if (bus.mem_wren) ram[bus.mem_addr] <= bus.mem_wdata;
        bus.mem_rdata <= ram[bus.mem_addr];
    end

    // Count every cycle with a RAM write strobe
    always @(negedge clock) begin
        if (bus.mem_wren) wren_cycles++;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic reportTimeout(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s: got timeout expected completion at t=%0t", name, $time);
    endtask

    // Drive one request and queue its expected response at the acceptance edge
    task automatic applyStimulus(input logic [1:0] op, input logic [WIDTH-1:0] data,
                                 input logic [WIDTH-1:0] exp_data, input logic exp_err,
                                 input int exp_lat);
        exp_t e;
        int   n = 0;
        while (!bus.req_ready && n < 20) begin
            @(negedge clock);
            n++;
        end
        if (!bus.req_ready) begin
            reportTimeout("req_ready_wait");
            return;
        end
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_data  = data;
        @(posedge clock);
        #1;
        e.data = exp_data;
        e.err  = exp_err;
        e.lat  = exp_lat;
        e.acc  = cyc;
        sb.push_back(e);
        bus.req_valid = 1'b0;
        bus.req_data  = '0;
    endtask

    // Wait until the monitor has consumed every queued response
    task automatic waitDone();
        for (int i = 0; i < 20; i++) begin
            @(posedge clock);
            #2;
            if (sb.size() == 0) return;
        end
        reportTimeout("response_wait");
        sb.delete();
    endtask

    // Response monitor: checks stability while held and scoreboard on handshake
    logic             prev_valid = 1'b0;
    logic [WIDTH-1:0] prev_data  = '0;
    logic             prev_err   = 1'b0;
    int               first_cyc  = 0;
    exp_t             got;
    always @(negedge clock) begin
        if (bus.resp_valid) begin
            if (!prev_valid) begin
                first_cyc = cyc;
            end else begin
                checkOutput("hold_resp_data", 32'(bus.resp_data), 32'(prev_data));
                checkOutput("hold_resp_err", 32'(bus.resp_err), 32'(prev_err));
            end
            checkOutput("req_ready_while_resp", 32'(bus.req_ready), 32'd0);
            if (bus.resp_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_resp: got data 0x%0h expected no response at t=%0t",
                             bus.resp_data, $time);
                end else begin
                    got = sb.pop_front();
                    checkOutput("resp_data", 32'(bus.resp_data), 32'(got.data));
                    checkOutput("resp_err", 32'(bus.resp_err), 32'(got.err));
                    checkOutput("resp_latency", 32'(first_cyc - got.acc + 1), 32'(got.lat));
                end
            end
        end
        prev_valid = bus.resp_valid;
        prev_data  = bus.resp_data;
        prev_err   = bus.resp_err;
    end

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_count"}, 32'(count), 32'd0);
        checkOutput({tag, "_empty"}, 32'(empty), 32'd1);
        checkOutput({tag, "_full"}, 32'(full), 32'd0);
        checkOutput({tag, "_req_ready"}, 32'(bus.req_ready), 32'd1);
        checkOutput({tag, "_resp_valid"}, 32'(bus.resp_valid), 32'd0);
        checkOutput({tag, "_resp_err"}, 32'(bus.resp_err), 32'd0);
        checkOutput({tag, "_resp_data"}, 32'(bus.resp_data), 32'd0);
        checkOutput({tag, "_mem_wren"}, 32'(bus.mem_wren), 32'd0);
        checkOutput({tag, "_mem_addr"}, 32'(bus.mem_addr), 32'd0);
        checkOutput({tag, "_mem_wdata"}, 32'(bus.mem_wdata), 32'd0);
    endtask

    // Watchdog so the run always terminates
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no end expected finish before 200us");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed test sequence
    initial begin
        int snap;
        bus.req_valid  = 1'b0;
        bus.req_op     = OP_PUSH;
        bus.req_data   = '0;
        bus.resp_ready = 1'b1;
        reset          = 1'b0;
        repeat (3) @(negedge clock);
        checkResetValues("por");
        reset = 1'b1;

        // Two pushes then a pop returning the later value; first push is
        // accepted on the very first edge out of reset (latency 2 proves it)
        $display("[TB] push/push/pop");
        applyStimulus(OP_PUSH, 16'h1234, 16'h1234, 1'b0, 2);
        waitDone();
        applyStimulus(OP_PUSH, 16'h00AB, 16'h00AB, 1'b0, 2);
        checkOutput("write_wren", 32'(bus.mem_wren), 32'd1);
        checkOutput("write_addr", 32'(bus.mem_addr), 32'd1);
        checkOutput("write_wdata", 32'(bus.mem_wdata), 32'h00AB);
        waitDone();
        checkOutput("count_after_2_push", 32'(count), 32'd2);
        applyStimulus(OP_POP, '0, 16'h00AB, 1'b0, 3);
        checkOutput("read_addr", 32'(bus.mem_addr), 32'd1);
        checkOutput("read_wren", 32'(bus.mem_wren), 32'd0);
        waitDone();
        checkOutput("count_after_pop", 32'(count), 32'd1);
        checkOutput("addr_held_idle", 32'(bus.mem_addr), 32'd1);
        applyStimulus(OP_POP, '0, 16'h1234, 1'b0, 3);
        waitDone();
        checkOutput("empty_after_pops", 32'(empty), 32'd1);

        // Underflow: pop, replace and peek on an empty stack
        $display("[TB] underflow");
        snap = wren_cycles;
        applyStimulus(OP_POP, '0, 16'h0000, 1'b1, 1);
        waitDone();
        applyStimulus(OP_REPL, 16'h7777, 16'h0000, 1'b1, 1);
        waitDone();
        applyStimulus(OP_PEEK, '0, 16'h0000, 1'b1, 1);
        waitDone();
        checkOutput("underflow_no_write", 32'(wren_cycles), 32'(snap));
        checkOutput("underflow_count", 32'(count), 32'd0);

        // Fill to DEPTH, overflow, then drain in LIFO order
        $display("[TB] fill and overflow");
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(OP_PUSH, 16'(i), 16'(i), 1'b0, 2);
            waitDone();
            checkOutput("full_early", 32'(full), (i == DEPTH - 1) ? 32'd1 : 32'd0);
        end
        checkOutput("count_full", 32'(count), 32'd32);
        checkOutput("ram_top", 32'(ram[31]), 32'd31);
        snap = wren_cycles;
        applyStimulus(OP_PUSH, 16'h0033, 16'h0000, 1'b1, 1);
        waitDone();
        checkOutput("overflow_count", 32'(count), 32'd32);
        checkOutput("overflow_no_write", 32'(wren_cycles), 32'(snap));
        checkOutput("overflow_addr_held", 32'(bus.mem_addr), 32'd31);
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(OP_POP, '0, 16'(DEPTH - 1 - i), 1'b0, 3);
            waitDone();
        end
        checkOutput("drained_empty", 32'(empty), 32'd1);

        // Replace-top and peek
        $display("[TB] replace and peek");
        applyStimulus(OP_PUSH, 16'h0005, 16'h0005, 1'b0, 2);
        waitDone();
        applyStimulus(OP_REPL, 16'h0009, 16'h0009, 1'b0, 2);
        waitDone();
        checkOutput("count_after_repl", 32'(count), 32'd1);
        applyStimulus(OP_PEEK, '0, 16'h0009, 1'b0, 3);
        waitDone();
        checkOutput("count_after_peek", 32'(count), 32'd1);
        applyStimulus(OP_POP, '0, 16'h0009, 1'b0, 3);
        waitDone();
        checkOutput("empty_after_repl_pop", 32'(empty), 32'd1);

        // Response back-pressure held for 4 cycles
        $display("[TB] response hold");
        applyStimulus(OP_PUSH, 16'h0BEE, 16'h0BEE, 1'b0, 2);
        waitDone();
        bus.resp_ready = 1'b0;
        applyStimulus(OP_POP, '0, 16'h0BEE, 1'b0, 3);
        snap = 0;
        while (!bus.resp_valid && snap < 10) begin
            @(negedge clock);
            snap++;
        end
        if (!bus.resp_valid) reportTimeout("hold_resp_valid_wait");
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            checkOutput("hold_valid", 32'(bus.resp_valid), 32'd1);
            checkOutput("hold_data_value", 32'(bus.resp_data), 32'h0BEE);
            checkOutput("hold_req_ready", 32'(bus.req_ready), 32'd0);
        end
        bus.resp_ready = 1'b1;
        waitDone();
        checkOutput("count_after_hold", 32'(count), 32'd0);

        // Reset in WAIT of a pop with three entries
        $display("[TB] reset mid-operation");
        for (int i = 1; i <= 3; i++) begin
            applyStimulus(OP_PUSH, 16'(i), 16'(i), 1'b0, 2);
            waitDone();
        end
        applyStimulus(OP_POP, '0, 16'h0003, 1'b0, 3);
        @(posedge clock);
        #1;
        checkOutput("wait_addr", 32'(bus.mem_addr), 32'd2);
        reset = 1'b0;
        sb.delete();
        #1;
        checkResetValues("async");
        repeat (2) @(negedge clock);
        reset = 1'b1;
        repeat (6) @(negedge clock);
        checkOutput("post_reset_count", 32'(count), 32'd0);
        checkOutput("post_reset_no_resp", 32'(bus.resp_valid), 32'd0);
        checkOutput("post_reset_ready", 32'(bus.req_ready), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gerente_pilha.md
GERENTE_PILHA -- requirements
Module: gerente_pilha

Interface
REQ-001 SHALL have parameter WIDTH, default 16, stack word width.
REQ-002 SHALL have parameter DEPTH, default 32, stack entries; AW = clog2(DEPTH), 5 at default.
REQ-003 SHALL have port clock  in  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-low reset; 0 forces the reset state immediately.
REQ-005 SHALL have port req_valid  in  1  requester has an operation pending.
REQ-006 SHALL have port req_ready  out  1  controller can accept an operation this cycle.
REQ-007 SHALL have port req_op  in  2  operation code: 00 push, 01 pop, 10 replace-top, 11 peek.
REQ-008 SHALL have port req_data  in  WIDTH  push or replace-top operand.
REQ-009 SHALL have port resp_valid  out  1  response is present.
REQ-010 SHALL have port resp_ready  in  1  requester accepts the response.
REQ-011 SHALL have port resp_data  out  WIDTH  popped, peeked or written word.
REQ-012 SHALL have port resp_err  out  1  operation rejected (overflow or underflow).
REQ-013 SHALL have port mem_addr  out  AW  stack RAM address.
REQ-014 SHALL have port mem_wren  out  1  stack RAM write enable.
REQ-015 SHALL have port mem_wdata  out  WIDTH  stack RAM write data.
REQ-016 SHALL have port mem_rdata  in  WIDTH  stack RAM read data, valid one clock after the address.
REQ-017 SHALL have port count  out  AW+1  number of occupied entries.
REQ-018 SHALL have ports full and empty  out  1 each  count==DEPTH and count==0.

Function
REQ-019 SHALL implement FSM states IDLE, WRITE, READ, WAIT and RESP; all outputs are registered, or are decoded from state and registers only.
REQ-020 req_ready SHALL be 1 only in IDLE; an operation is accepted when req_valid and req_ready are both 1, and req_op and req_data are captured at acceptance.
REQ-021 Push with full=1, or pop/replace/peek with empty=1, SHALL go IDLE->RESP with resp_err=1 and resp_data=0; no memory access and count unchanged.
REQ-022 Push SHALL go IDLE->WRITE->RESP: in WRITE mem_addr=count, mem_wren=1 and mem_wdata=data, and count increments at the end of WRITE; resp_data=data.
REQ-023 Replace-top SHALL go IDLE->WRITE->RESP, writing at address count-1; count is unchanged and resp_data=data.
REQ-024 Pop and peek SHALL go IDLE->READ->WAIT->RESP: mem_addr=count-1 in READ and WAIT, and mem_rdata is registered into resp_data at the end of WAIT; pop decrements count at the end of WAIT, peek leaves count unchanged.
REQ-025 mem_wren SHALL be 1 only in WRITE.
REQ-026 mem_addr SHALL hold its last value outside READ, WAIT and WRITE.
REQ-027 Latency from acceptance edge T: error response valid at T+1, write response valid at T+2, read response valid at T+3.
REQ-028 resp_valid SHALL be 1 exactly in RESP; RESP->IDLE occurs when resp_ready=1, otherwise RESP holds with resp_data and resp_err stable.
REQ-029 While resp_valid=1, the next operation SHALL NOT be accepted; single outstanding operation.
REQ-030 Address arithmetic SHALL be AW bits wide; count SHALL be AW+1 bits wide and never exceed DEPTH or go below 0.
REQ-031 full and empty SHALL reflect the count already updated in the cycle after the update edge.

Reset
REQ-032 On reset=0, regardless of state (mid-operation included), the block SHALL enter IDLE with count=0, empty=1, full=0, req_ready=1, resp_valid=0, resp_err=0, resp_data=0, mem_wren=0, mem_addr=0 and mem_wdata=0.
REQ-033 An operation interrupted by reset SHALL produce no response and SHALL leave count=0; RAM contents are don't-care.
REQ-034 The first operation SHALL be accepted on the first rising edge with reset=1 and req_valid=1.

Verification
REQ-035 Push 0x1234, then push 0x00AB, then pop -> resp_data 0x00AB at T+3, resp_err=0, count 2->1.
REQ-036 Pop while empty -> resp_err=1 and resp_valid at T+1, mem_wren never 1, count stays 0.
REQ-037 32 pushes of values 0..31, then a 33rd push -> full=1 after the 32nd push; 33rd gives resp_err=1 and count stays 32.
REQ-038 Push 5, replace-top 9, peek -> peek returns 9 and count=1; then pop returns 9 and empty=1.
REQ-039 Hold resp_ready=0 for 4 cycles after a pop response -> resp_valid, resp_data and req_ready stable (req_ready=0) for all 4 cycles.
REQ-040 Assert reset=0 in WAIT of a pop with count=3 -> outputs reach reset values immediately, no response, count=0.
